mac_result_collector: RTL and testbench
=======================================

Name: mac_result_collector

Overview:
- Downstream stage of the MAC block: consumes its C output and delivers completed results to the readout/interconnect side via a valid/ready stream.
- Tracks which issued MAC operations produce a result, aligned to the MAC pipeline latency:
  - multiply-only ops produce one result each;
  - accumulate runs produce one result at the last op.
- Buffers results in a small FIFO and applies credit-based backpressure to the operand issuer.

Parameters:
- ACC_WIDTH, `MAC_ACC_WIDTH: width of MAC result and stored data.
- LATENCY, 1: cycles from MAC op issue (en/operands presented) to valid C.
- DEPTH, 4: FIFO entries, power of 2, ≥2.
- CNT_WIDTH, 8: width of per-result operation count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  MAC op issued this cycle; same cycle the MAC block sees en/operands.
- in_ready  output  1  issuer may assert in_valid this cycle.
- in_last  input  1  final op of an accumulate run; ignored in multiply-only mode.
- in_acc_mode  input  1  copy of the MAC config accumulate bit (cfg[`MAC_CONF_WIDTH-1]) for this op.
- mac_c  input  ACC_WIDTH  MAC block C output.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  ACC_WIDTH  result value.
- out_count  output  CNT_WIDTH  number of ops folded into this result.
- err_overflow  output  1  sticky: op accepted while in_ready low.
- err_clear  input  1  clears err_overflow.

Behaviour:
- Decided: single clock clk; reset rst synchronous, active-high.
- Reset values: out_valid=0, err_overflow=0, in_ready=1. Pipeline tags, FIFO pointers/occupancy and run counter are all cleared. A reset mid-run discards in-flight ops and the partial count; no result is emitted for them.
- Tag pipeline: LATENCY stages of {valid, last, acc_mode}, advancing every cycle; there is no stall.
- Commit: when a tag reaches stage LATENCY with valid=1, mac_c is sampled that same cycle.
- Push rule:
  - acc_mode=0: push {mac_c, count=1}.
  - acc_mode=1, last=0: increment run_cnt; no push.
  - acc_mode=1, last=1: push {mac_c, run_cnt+1}, then run_cnt←0.
- run_cnt saturates at 2^CNT_WIDTH-1. The pushed count also saturates and never wraps.
- A mode switch mid-run is not legal. If a multiply-only op commits while run_cnt≠0, run_cnt is discarded to 0; the multiply-only push proceeds normally.
- Credits: pending = number of valid in-flight tags whose push condition holds (acc_mode=0 or last=1).
  - in_ready = (occupancy + pending) < DEPTH, combinational on registered state.
  - An in_valid that does not push (acc, last=0) still requires in_ready=1.
- Illegal issue (in_valid=1 while in_ready=0): the op is still tracked. If its push then finds the FIFO full, the result is dropped. err_overflow sets on the illegal issue cycle and holds until err_clear or rst; err_clear has priority over a same-cycle set.
- FIFO: first-word-fall-through. out_data/out_count are valid whenever out_valid=1 and hold stable until out_valid&out_ready.
- Simultaneous push and pop: allowed at any occupancy including full (pop frees the slot), occupancy unchanged. Pointers wrap modulo DEPTH.
- Empty: out_valid=0; a push is visible at the output the next cycle, giving 1-cycle minimum commit→out_valid latency.
- Throughput: one result per cycle sustained when out_ready=1.

Decomposition:
- mac_const.vh additions: `MAC_COLLECT_DEPTH (4), `MAC_COLLECT_CNT_WIDTH (8), `MAC_PIPE_LATENCY (1).
- Tag-field bit indices are defined as localparams in the collector.
- One sub-module: mac_result_fifo.
  - Parameterized WIDTH (ACC_WIDTH+CNT_WIDTH) and DEPTH, first-word-fall-through, sync reset.
  - Ports: push, pop, din, dout, empty, full, count.
- The collector holds the tag pipeline, run counter, credit logic and error flag.

Test Plan:
- Multiply-only stream: 3 ops on consecutive cycles, mac_c=0x10,0x20,0x30 one cycle after each issue, out_ready=1 → out_data 0x10,0x20,0x30 on consecutive cycles, out_count=1 each.
- Accumulate run: 5 ops with in_last on the 5th, mac_c at its commit=0x0000_0123 → single result 0x123, out_count=5; no out_valid earlier.
- Backpressure: out_ready=0, DEPTH=4, issue multiply-only ops every cycle → in_ready low after 4 issued, exactly 4 entries held, no err. Raise out_ready → drains in order, in_ready returns the cycle after the first pop.
- Full simultaneous push/pop: FIFO full, out_ready=1, one op in flight → occupancy stays 4, order preserved, no drop.
- Violation: force in_valid while in_ready=0 with FIFO full → err_overflow=1 sticky, result dropped, FIFO contents intact; err_clear → 0.
- Reset mid-run: 3 acc ops issued, rst for 1 cycle, then a 2-op run → one result, out_count=2; out_valid=0 throughout reset.
- Saturation: 300-op run → out_count=255.

Source files
------------

// File: rtl/mac_result_collector_pkg.sv
// Shared constants for the MAC result collector slice.
//
// Holds the default widths and depths used by the collector and its FIFO:
//   MAC_ACC_WIDTH         - width of the MAC C output / stored result
//   MAC_COLLECT_DEPTH     - result FIFO entries (power of 2, >= 2)
//   MAC_COLLECT_CNT_WIDTH - width of the per-result op count
//   MAC_PIPE_LATENCY      - cycles from MAC op issue to valid C
package mac_result_collector_pkg;

  localparam int MAC_ACC_WIDTH         = 32;
  localparam int MAC_COLLECT_DEPTH     = 4;
  localparam int MAC_COLLECT_CNT_WIDTH = 8;
  localparam int MAC_PIPE_LATENCY      = 1;

endpackage

// File: rtl/mac_result_fifo.sv
// First-word-fall-through result FIFO with synchronous active-high reset.
//
// Ports:
//   clk, rst - clock and synchronous reset
//   push     - write din this cycle (ignored when full unless a pop frees a slot)
//   pop      - consume the head entry (ignored when empty)
//   din      - entry to write
//   dout     - head entry, valid whenever empty is low
//   empty    - no entries held
//   full     - DEPTH entries held
//   count    - number of entries held
module mac_result_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/mac_result_collector.sv
// Collects completed MAC results and streams them out over valid/ready.
//
// Each issued op is tagged {valid, last, acc_mode} and the tag is delayed by
// the MAC latency so it lines up with mac_c. Multiply-only ops push one result
// each; accumulate runs push one result at their last op, carrying the number
// of ops folded in. The issuer is throttled by credits: FIFO occupancy plus
// in-flight ops that will push must stay below DEPTH.
//
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   in_valid       - MAC op issued this cycle
//   in_ready       - issuer may assert in_valid this cycle
//   in_last        - final op of an accumulate run
//   in_acc_mode    - accumulate-mode bit of the op's MAC config
//   mac_c          - MAC block C output
//   out_valid      - result available at the head
//   out_ready      - consumer accepts the head
//   out_data       - result value
//   out_count      - number of ops folded into the result
//   err_overflow   - sticky flag: op issued while in_ready was low
//   err_clear      - clears err_overflow (wins over a same-cycle set)
module mac_result_collector
  import mac_result_collector_pkg::*;
#(
  parameter int ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int LATENCY   = MAC_PIPE_LATENCY,
  parameter int DEPTH     = MAC_COLLECT_DEPTH,
  parameter int CNT_WIDTH = MAC_COLLECT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic                 in_acc_mode,
  input  logic [ACC_WIDTH-1:0] mac_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 err_overflow,
  input  logic                 err_clear
);

  localparam int TAG_VALID = 2;
  localparam int TAG_LAST  = 1;
  localparam int TAG_ACC   = 0;
  localparam int OCC_W     = $clog2(DEPTH) + 1;
  localparam int SUM_W     = $clog2(DEPTH + LATENCY + 1) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [2:0]                     tag_pipe [LATENCY];
  logic [2:0]                     commit_tag;
  logic [CNT_WIDTH-1:0]           run_cnt;
  logic [CNT_WIDTH-1:0]           run_cnt_next;
  logic [CNT_WIDTH-1:0]           run_cnt_inc;
  logic [CNT_WIDTH-1:0]           push_cnt;
  logic                           commit_push;
  logic                           fifo_push;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic [OCC_W-1:0]               fifo_count;
  logic [ACC_WIDTH+CNT_WIDTH-1:0] fifo_dout;
  logic [SUM_W-1:0]               pending;

  // A tag that will eventually push a FIFO entry when it commits.
  function automatic logic tag_pushes(input logic [2:0] tag);
    return tag[TAG_VALID] & (~tag[TAG_ACC] | tag[TAG_LAST]);
  endfunction

  // Tag shift register; never stalls, mirrors the MAC pipeline exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= {in_valid, in_last, in_acc_mode};
      for (int i = 1; i < LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign commit_tag  = tag_pipe[LATENCY-1];
  assign run_cnt_inc = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_WIDTH'(1);

  // Commit decision; a multiply-only op also discards any stray partial run.
  always_comb begin
    commit_push  = 1'b0;
    push_cnt     = CNT_WIDTH'(1);
    run_cnt_next = run_cnt;
    if (commit_tag[TAG_VALID]) begin
      if (!commit_tag[TAG_ACC]) begin
        commit_push  = 1'b1;
        run_cnt_next = '0;
      end else if (!commit_tag[TAG_LAST]) begin
        run_cnt_next = run_cnt_inc;
      end else begin
        commit_push  = 1'b1;
        push_cnt     = run_cnt_inc;
        run_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt_next;
    end
  end

  // Results arriving at a full FIFO with no pop are dropped (only after an
  // illegal issue can this happen).
  assign fifo_push = commit_push & (~fifo_full | out_ready);

  // Credits reserved by in-flight ops that will push.
  always_comb begin
    pending = '0;
    for (int i = 0; i < LATENCY; i++) begin
      pending = pending + SUM_W'(tag_pushes(tag_pipe[i]));
    end
  end

  assign in_ready = (SUM_W'(fifo_count) + pending) < SUM_W'(DEPTH);

  // Sticky overflow flag; clear takes priority over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
    end else if (err_clear) begin
      err_overflow <= 1'b0;
    end else if (in_valid && !in_ready) begin
      err_overflow <= 1'b1;
    end
  end

  mac_result_fifo #(
    .WIDTH(ACC_WIDTH + CNT_WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (out_ready),
    .din   ({mac_c, push_cnt}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign out_valid              = ~fifo_empty;
  assign {out_data, out_count}  = fifo_dout;

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector (default parameters:
// ACC_WIDTH=32, LATENCY=1, DEPTH=4, CNT_WIDTH=8).
module tb_mac_result_collector;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        in_acc_mode;
  logic [31:0] mac_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        err_overflow;
  logic        err_clear;

  logic [31:0] issue_data;
  exp_t        exp_q[$];
  int          checks;
  int          errors;

  mac_result_collector dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_acc_mode  (in_acc_mode),
    .mac_c        (mac_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .err_overflow (err_overflow),
    .err_clear    (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC block model: C appears one cycle after the op is issued.
  always @(posedge clk) mac_c <= issue_data;

  // Scoreboard: every accepted head must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output got data=%h count=%0d expected none", out_data, out_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_count !== e.cnt) begin
          errors++;
          $display("[TB] FAIL result got data=%h count=%0d expected data=%h count=%0d",
                   out_data, out_count, e.data, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic acc, input logic last, input logic [31:0] data);
    in_valid    = 1'b1;
    in_acc_mode = acc;
    in_last     = last;
    issue_data  = data;
    tick();
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_acc_mode = 1'b0;
    in_last     = 1'b0;
    issue_data  = 32'h0;
    tick();
  endtask

  task automatic expect_result(input logic [31:0] data, input logic [7:0] cnt);
    exp_t e;
    e.data = data;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      idle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("[TB] FAIL drain got pending=%0d out_valid=%b expected pending=0 out_valid=0",
               exp_q.size(), out_valid);
    end
  endtask

  // Fill the FIFO with legal multiply-only ops while out_ready is low.
  task automatic fill_fifo(input logic [31:0] base, output int issued);
    issued = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin
        expect_result(base + 32'(issued), 8'd1);
        issue(1'b0, 1'b0, base + 32'(issued));
        issued++;
      end else begin
        idle();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got valid=%b ready=%b err=%b expected 0 1 0",
               out_valid, in_ready, err_overflow);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_mult_stream();
    out_ready = 1'b1;
    expect_result(32'h10, 8'd1);
    issue(1'b0, 1'b0, 32'h10);
    expect_result(32'h20, 8'd1);
    issue(1'b0, 1'b0, 32'h20);
    expect_result(32'h30, 8'd1);
    issue(1'b0, 1'b0, 32'h30);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mult_consecutive_1 got valid=%b expected 1", out_valid);
    end
    idle();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mult_consecutive_2 got valid=%b expected 1", out_valid);
    end
    idle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mult_stream_end got valid=%b expected 0", out_valid);
    end
    drain();
  endtask

  task automatic test_acc_run();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, $urandom);
    end
    expect_result(32'h0000_0123, 8'd5);
    issue(1'b1, 1'b1, 32'h0000_0123);
    drain();
  endtask

  task automatic test_backpressure();
    int issued;
    fill_fifo(32'hB000, issued);
    checks++;
    if (issued != 4 || in_ready !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure got issued=%0d ready=%b err=%b expected 4 0 0",
               issued, in_ready, err_overflow);
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_pop got %b expected 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_pop got %b expected 1", in_ready);
    end
    drain();
  endtask

  task automatic test_violation();
    int issued;
    fill_fifo(32'hC000, issued);
    issue(1'b0, 1'b0, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set got %b expected 1", err_overflow);
    end
    idle();
    idle();
    idle();
    checks++;
    if (err_overflow !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_sticky got err=%b ready=%b expected 1 0", err_overflow, in_ready);
    end
    err_clear = 1'b1;
    idle();
    err_clear = 1'b0;
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_clear got %b expected 0", err_overflow);
    end
    drain();
  endtask

  task automatic test_full_push_pop();
    int issued;
    fill_fifo(32'hD000, issued);
    // Illegal issue at full with err_clear held: clear must win.
    err_clear = 1'b1;
    expect_result(32'hD0FF, 8'd1);
    issue(1'b0, 1'b0, 32'hD0FF);
    err_clear = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_priority got %b expected 0", err_overflow);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_push_pop got ready=%b valid=%b expected 0 1", in_ready, out_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, 32'h5000 + 32'(i));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_run got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    rst = 1'b0;
    issue(1'b1, 1'b0, 32'h6000);
    expect_result(32'h0000_6001, 8'd2);
    issue(1'b1, 1'b1, 32'h0000_6001);
    drain();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 299; i++) begin
      issue(1'b1, 1'b0, $urandom);
    end
    expect_result(32'hABCD_0300, 8'd255);
    issue(1'b1, 1'b1, 32'hABCD_0300);
    drain();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_acc_mode = 1'b0;
    issue_data  = 32'h0;
    out_ready   = 1'b0;
    err_clear   = 1'b0;
    test_reset();
    test_mult_stream();
    test_acc_run();
    test_backpressure();
    test_violation();
    test_full_push_pop();
    test_reset_mid_run();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
